// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - one-hot line decoder with direct select and prescaled auto-scan
module decoder_scan #(
    parameter int SEL_W      = 2,
    parameter int DIV_W      = 17,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      s,
    input  logic [DIV_W-1:0]      div,
    output logic [2**SEL_W-1:0]   D,
    output logic [SEL_W-1:0]      idx,
    output logic                  tick
);

    localparam int N = 2**SEL_W;
    localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] D_OFF = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic {
        DIRECT = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  cnt_next;
    logic [SEL_W-1:0]  idx_next;
    logic              tick_next;
    logic [N-1:0]      d_next;

    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] i);
        logic [N-1:0] oh;
        oh = ONE << i;
        return (ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIRECT;
            cnt   <= '0;
            idx   <= '0;
            tick  <= 1'b0;
            D     <= D_OFF;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            tick  <= tick_next;
            D     <= d_next;
        end
    end

    // Disabled edges blank D but keep idx/cnt/state so scanning resumes mid-period.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        tick_next  = 1'b0;
        d_next     = D_OFF;
        if (en) begin
            state_next = mode ? SCAN : DIRECT;
            if (!mode) begin
                idx_next = s;
                cnt_next = '0;
            end else if (state == SCAN) begin
                // >= so a div lowered below cnt terminates the period at once
                if (cnt >= div) begin
                    cnt_next  = '0;
                    idx_next  = idx + SEL_W'(1);
                    tick_next = 1'b1;
                end else begin
                    cnt_next = cnt + DIV_W'(1);
                end
            end else begin
                cnt_next = '0;
            end
            d_next = decode(idx_next);
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - directed self-checking bench for decoder_scan
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [1:0] s;
    logic [3:0] div;
    logic [3:0] D;
    logic [1:0] idx;
    logic       tick;
    logic [3:0] D_al;
    logic [1:0] idx_al;
    logic       tick_al;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(2), .DIV_W(4), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .div(div),
        .D(D), .idx(idx), .tick(tick)
    );

    decoder_scan #(.SEL_W(2), .DIV_W(4), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .div(div),
        .D(D_al), .idx(idx_al), .tick(tick_al)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_idx, input logic e_tick);
        logic [3:0] e_d;
        e_d = 4'b0001 << e_idx;
        check({tag, ".idx"}, 32'(idx), 32'(e_idx));
        check({tag, ".D"}, 32'(D), 32'(e_d));
        check({tag, ".tick"}, 32'(tick), 32'(e_tick));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; s = 2'd0; div = 4'd0;
        step(2);
        check("rst.idx", 32'(idx), 32'd0);
        check("rst.D", 32'(D), 32'h0);
        check("rst.tick", 32'(tick), 32'd0);
        check("rst.D_al", 32'(D_al), 32'hf);

        // direct decode, one-cycle latency
        rst = 1'b0; en = 1'b1; mode = 1'b0; s = 2'd2;
        step(1);
        check("dir2.D", 32'(D), 32'h4);
        check_out("dir2", 2'd2, 1'b0);
        s = 2'd3;
        step(1);
        check("dir3.D", 32'(D), 32'h8);
        s = 2'd1;
        step(1);
        check("dir1.D_al", 32'(D_al), 32'hd);
        s = 2'd0;
        step(1);
        check_out("dir0", 2'd0, 1'b0);

        // auto-scan div=2: advance every 3 cycles, wrap 3->0
        mode = 1'b1; div = 4'd2;
        step(1);
        check_out("enter", 2'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(2);
            check_out("scan_wait", 2'((k - 1) % 4), 1'b0);
            step(1);
            check_out("scan_adv", 2'(k % 4), 1'b1);
        end

        // div=0: advance every cycle, tick stays high
        div = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check_out("div0", 2'(k % 4), 1'b1);
        end

        // div lowered below running count terminates the period next edge
        div = 4'd9;
        step(5);
        check_out("div9", 2'd1, 1'b0);
        div = 4'd1;
        step(1);
        check_out("div_drop", 2'd2, 1'b1);

        // enable gap preserves cnt (cnt=1 entering the gap, div=3)
        div = 4'd3;
        step(1);
        check_out("pre_gap", 2'd2, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("gap.D", 32'(D), 32'h0);
            check("gap.idx", 32'(idx), 32'd2);
            check("gap.tick", 32'(tick), 32'd0);
        end
        en = 1'b1;
        step(1);
        check_out("resume", 2'd2, 1'b0);
        step(1);
        check_out("resume2", 2'd2, 1'b0);
        step(1);
        check_out("resume_adv", 2'd3, 1'b1);

        // scan -> direct takes s on that edge
        mode = 1'b0; s = 2'd1;
        step(1);
        check_out("to_direct", 2'd1, 1'b0);

        // rst mid-scan, then restart from reset state
        mode = 1'b1; div = 4'd1;
        step(2);
        rst = 1'b1;
        step(1);
        check("mid_rst.idx", 32'(idx), 32'd0);
        check("mid_rst.D", 32'(D), 32'h0);
        check("mid_rst.tick", 32'(tick), 32'd0);
        check("mid_rst.D_al", 32'(D_al), 32'hf);
        rst = 1'b0;
        step(1);
        check_out("post_rst", 2'd0, 1'b0);
        step(1);
        check_out("post_rst2", 2'd0, 1'b0);
        step(1);
        check_out("post_rst_adv", 2'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter SEL_W, default 2, select/index width; number of outputs N = 2**SEL_W.
REQ-002 Parameter DIV_W, default 17, prescaler counter width.
REQ-003 Parameter ACTIVE_LOW, default 0; 1 inverts every bit of D (asserted line = 0).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  output enable; 0 blanks D and freezes scanning.
REQ-007 mode  input  1  0 = direct decode of s, 1 = auto-scan.
REQ-008 s  input  SEL_W  select value used in direct mode.
REQ-009 div  input  DIV_W  scan period minus one, in clk cycles.
REQ-010 D  output  N  registered one-hot decode of idx, polarity per ACTIVE_LOW.
REQ-011 idx  output  SEL_W  registered current index.
REQ-012 tick  output  1  registered one-cycle pulse on each scan advance.

Function
REQ-013 Two-state FSM, DIRECT and SCAN; next state = SCAN when mode=1, else DIRECT, sampled every edge while en=1.
REQ-014 D and idx update on the same edge; at every cycle with en=1 at the last edge, D = one-hot(idx), bit idx asserted, all others deasserted.
REQ-015 Direct mode: idx <= s each edge; latency s->idx/D = 1 cycle; tick = 0.
REQ-016 Scan mode: prescaler cnt increments by 1 each edge; when cnt >= div: cnt <= 0, idx <= idx+1, tick <= 1; otherwise tick <= 0.
REQ-017 idx wraps from N-1 to 0 (modulo-N); no other idx value is skipped or repeated.
REQ-018 div = 0 advances idx every cycle, tick held 1 continuously.
REQ-019 div reduced below current cnt mid-period: next edge is treated as terminal (>= compare), no counter overrun.
REQ-020 Transition DIRECT->SCAN: cnt <= 0; scanning continues from the idx held at the transition; first advance occurs div+1 cycles after the edge that entered SCAN.
REQ-021 Transition SCAN->DIRECT: cnt <= 0, tick <= 0, idx <= s on that edge.
REQ-022 en=0 at an edge: D <= all deasserted, tick <= 0, idx, cnt and FSM state held.
REQ-023 en returning to 1: D <= one-hot(idx) on that edge; scan resumes with preserved cnt.
REQ-024 Simultaneous rst with any other input: rst wins.
REQ-025 cnt is DIV_W bits wide; no width truncation of div.

Reset
REQ-026 rst=1 at an edge: FSM <= DIRECT, cnt <= 0, idx <= 0, tick <= 0, D <= all deasserted (0 for ACTIVE_LOW=0, all-ones for ACTIVE_LOW=1).
REQ-027 rst asserted mid-scan aborts the period; first edge after rst release behaves per REQ-015/REQ-016 from the reset state.
REQ-028 No output is X after the first rst edge.

Verification (SEL_W=2, DIV_W=4, ACTIVE_LOW=0 unless stated)
REQ-029 rst, then en=1, mode=0, s=2 -> next cycle idx=2, D=4'b0100, tick=0; s=3 -> D=4'b1000 one cycle later.
REQ-030 en=1, mode=1, div=2 from idx=0 -> idx 1,2,3,0 every 3 cycles, tick high exactly one cycle per advance, D tracks idx each cycle.
REQ-031 Scan with div=0 -> idx increments every cycle, wraps 3->0, tick constantly 1; then div changed 9->1 while cnt=5 -> advance on very next edge.
REQ-032 Scanning at idx=1, en=0 for 4 cycles -> D=4'b0000, idx stays 1, tick=0; en=1 -> D=4'b0010 next edge, period resumes from stored cnt.
REQ-033 Scanning, mode dropped to 0 with s=3 -> next cycle idx=3, D=4'b1000, tick=0; rst mid-scan -> idx=0, D=4'b0000.
REQ-034 ACTIVE_LOW=1 build, direct s=1 -> D=4'b1101; after rst D=4'b1111.
